ip_rx_filter: RTL and testbench
===============================

// Module: ip_rx_filter
// PURPOSE
//  RX-side IPv4 header stage, downstream of the Ethernet header stripper and upstream of the UDP parser.
//  Consumes a byte stream that starts at the first IP header byte and assembles the 20-byte header.
//  Verifies version, IHL, checksum, protocol and destination address.
//  Forwards exactly (tot_len-20) payload bytes; drops bad frames whole and discards trailing Ethernet padding.
// PARAMETERS
//  LOCAL_ADDR   32'hC0A8_0165  accepted daddr (192.168.1.101)
//  CHECK_DADDR  1              1: daddr must equal LOCAL_ADDR; 0: any daddr accepted
// PORTS
//  clk156       in   1    the single clock
//  eth_rst      in   1    reset, asynchronous, active-high
//  s_tdata      in   8    input byte; first byte of a frame = version/ihl
//  s_tvalid     in   1    input valid
//  s_tready     out  1    input ready
//  s_tlast      in   1    last byte of input frame (incl. padding)
//  m_tdata      out  8    IP payload byte (UDP header first)
//  m_tvalid     out  1    output valid
//  m_tready     in   1    output ready
//  m_tlast      out  1    last payload byte
//  hdr          out  iphdr  captured header; held from accept until next accept
//  hdr_valid    out  1    1-cycle pulse when a header is accepted
//  len_err      out  1    1-cycle pulse when s_tlast arrives before tot_len is reached
// BEHAVIOUR
//  Reset: state=HDR, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, hdr=0, hdr_valid=0, len_err=0, counters=0.
//  States:
//   HDR      s_tready=1; shift bytes into hdr (MSB first); add each 16-bit word into a 24-bit sum.
//            tlast before byte 20: go to HDR (runt, no output).
//            After byte 20 (without tlast): go to CHECK.
//            If byte 20 carries tlast: header only, so drop it; count it as bad and stay in HDR.
//   CHECK    s_tready=0 for 1 cycle. ok = all of:
//            ip_checksum1(sum)==0; version==4; ihl==5; protocol==8'h11; tot_len>=28;
//            (!CHECK_DADDR || daddr==LOCAL_ADDR).
//            ok: pulse hdr_valid, load rem=tot_len-20 (16b), go to PAYLOAD. !ok: go to DROP.
//   PAYLOAD  1-entry registered output. s_tready = !m_tvalid || m_tready. Latency: 1 cycle input->output.
//            Each accepted byte decrements rem; m_tlast=1 on the byte where rem==1 or on s_tlast, whichever first.
//            rem hits 1 without s_tlast: go to DROP (discard padding).
//            rem hits 1 with s_tlast: go to HDR.
//            s_tlast with rem>1: go to HDR and pulse len_err; the byte still goes out with m_tlast=1.
//   DROP     s_tready=1; discard until an s_tlast byte is accepted, then go to HDR.
//  m_tvalid holds with stable m_tdata/m_tlast until m_tready. s_tvalid low: no state change.
//  Checksum: the sum includes the check field, so a correct header folds to 16'hFFFF and complements to 0.
//   Use 24-bit accumulation and a one-step fold, identical to ip_checksum0/1.
//  Reset mid-frame: immediate return to HDR, output cleared. The remainder of the interrupted frame is parsed as a header and fails.
// CONFIGURATION
//  IP_RX_FILTER_STATS_EN defined: adds outputs stat_ok [31:0], stat_bad [31:0], stat_runt [31:0].
//   Free-running, wrap at 2^32, cleared only by eth_rst.
//   stat_ok increments on hdr_valid; stat_bad on each CHECK failure; stat_runt on each HDR runt.
//  Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  ip_pkg holds iphdr, ip_checksum0/ip_checksum1, IP4_PROTO_UDP, IPVERSION and IP_HDR_DEFLEN (20; header byte count).
//  New in ip_pkg: ip_hdr_ok() function (CHECK-state predicate).
//  One sub-module: ip_csum_acc (16-bit word adder with 24-bit accumulator, clear/add/fold).
// TESTING
//  1. Valid 60-byte input frame, tot_len=46, daddr=192.168.1.101, proto=0x11, correct check
//     -> hdr_valid once; 26 bytes out; m_tlast on byte 26; 14 pad bytes dropped.
//  2. Same frame with check field XOR 16'h0001 -> no m_tvalid; stat_bad=1; next good frame passes.
//  3. Frame with tlast at byte 12 -> no output, stat_runt=1, state HDR; the following frame is parsed correctly.
//  4. tot_len=100, s_tlast after 40 payload bytes -> 40 bytes out, m_tlast on byte 40, len_err pulse.
//  5. Scenario 1 with m_tready toggling 1010... -> byte order and count unchanged, no loss or duplication,
//     s_tready low whenever m_tvalid && !m_tready.
//  6. daddr=192.168.2.102: CHECK_DADDR=1 -> dropped; CHECK_DADDR=0 -> forwarded.
//     Also: eth_rst asserted mid-payload -> all outputs at reset values next edge.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: header layout, checksum folding and the header acceptance predicate.
package ip_pkg;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] tot_len;
        logic [15:0] id;
        logic [15:0] frag_off;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] check;
        logic [31:0] saddr;
        logic [31:0] daddr;
    } iphdr;

    localparam logic [7:0]  IP4_PROTO_UDP  = 8'h11;
    localparam logic [3:0]  IPVERSION      = 4'd4;
    localparam int          IP_HDR_DEFLEN  = 20;
    localparam logic [3:0]  IP_HDR_IHL     = 4'd5;
    localparam logic [15:0] IP_MIN_TOT_LEN = 16'd28;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_CHECK   = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } rx_state_e;

    // A 20-byte header sums to at most 10*16'hFFFF, so one fold of the carry byte suffices.
    function automatic logic [15:0] ip_checksum0(input logic [23:0] sum);
        return sum[15:0] + {8'h00, sum[23:16]};
    endfunction

    function automatic logic [15:0] ip_checksum1(input logic [23:0] sum);
        return ~ip_checksum0(sum);
    endfunction

    function automatic logic ip_hdr_ok(input iphdr       h,
                                       input logic [15:0] csum,
                                       input logic        chk_daddr,
                                       input logic [31:0] local_addr);
        return (csum == 16'h0000) &&
               (h.version == IPVERSION) &&
               (h.ihl == IP_HDR_IHL) &&
               (h.protocol == IP4_PROTO_UDP) &&
               (h.tot_len >= IP_MIN_TOT_LEN) &&
               (!chk_daddr || (h.daddr == local_addr));
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// 16-bit word adder into a 24-bit accumulator; exposes the folded, complemented checksum.
module ip_csum_acc
    import ip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [23:0] sum,
    output logic [15:0] csum
);

    logic [23:0] sum_d;
    logic [23:0] sum_q;

    // Clear has priority so a new header never inherits a stale partial sum.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 24'h00_0000;
        end else if (add) begin
            sum_d = sum_q + {8'h00, word};
        end else begin
            sum_d = sum_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 24'h00_0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum  = sum_q;
    assign csum = ip_checksum1(sum_q);

endmodule

// File: rtl/ip_rx_filter.sv
// RX IPv4 header filter: assembles and checks the header, forwards tot_len-20 payload bytes.
// Optional statistics counters are enabled with `define IP_RX_FILTER_STATS_EN.
module ip_rx_filter
    import ip_pkg::*;
#(
    parameter logic [31:0] LOCAL_ADDR  = 32'hC0A8_0165,
    parameter bit          CHECK_DADDR = 1'b1
) (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output iphdr        hdr,
    output logic        hdr_valid,
    output logic        len_err
`ifdef IP_RX_FILTER_STATS_EN
    ,
    output logic [31:0] stat_ok,
    output logic [31:0] stat_bad,
    output logic [31:0] stat_runt
`endif
);

    rx_state_e    state_q, state_d;
    logic [159:0] shift_q, shift_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [15:0]  rem_q, rem_d;
    iphdr         hdr_q, hdr_d;
    logic         hdr_valid_q, hdr_valid_d;
    logic         len_err_q, len_err_d;
    logic         m_tvalid_q, m_tvalid_d;
    logic         m_tlast_q, m_tlast_d;
    logic [7:0]   m_tdata_q, m_tdata_d;

    logic         ready_s;
    logic         s_fire_s;
    logic         csum_clr_s;
    logic         csum_add_s;
    logic         runt_s;
    logic         bad_s;
    logic [23:0]  sum_s;
    logic [15:0]  csum_s;

    ip_csum_acc u_csum (
        .clk  (clk156),
        .rst  (eth_rst),
        .clr  (csum_clr_s),
        .add  (csum_add_s),
        .word ({shift_q[7:0], s_tdata}),
        .sum  (sum_s),
        .csum (csum_s)
    );

    // Input ready per state; held low while reset is asserted.
    always_comb begin
        case (state_q)
            ST_HDR:     ready_s = 1'b1;
            ST_CHECK:   ready_s = 1'b0;
            ST_PAYLOAD: ready_s = !m_tvalid_q || m_tready;
            ST_DROP:    ready_s = 1'b1;
            default:    ready_s = 1'b0;
        endcase
    end

    assign s_tready = ready_s & ~eth_rst;
    assign s_fire_s = s_tvalid & s_tready;

    // Next-state and datapath for the header/check/payload/drop sequence.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        len_err_d   = 1'b0;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        csum_clr_s  = 1'b0;
        csum_add_s  = 1'b0;
        runt_s      = 1'b0;
        bad_s       = 1'b0;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end

        case (state_q)
            ST_HDR: begin
                if (s_fire_s) begin
                    shift_d    = {shift_q[151:0], s_tdata};
                    cnt_d      = cnt_q + 5'd1;
                    csum_add_s = cnt_q[0];
                    if (s_tlast) begin
                        // A frame ending at or before byte 20 has no payload to forward.
                        cnt_d      = 5'd0;
                        csum_clr_s = 1'b1;
                        state_d    = ST_HDR;
                        if (cnt_q == 5'(IP_HDR_DEFLEN - 1)) begin
                            bad_s = 1'b1;
                        end else begin
                            runt_s = 1'b1;
                        end
                    end else if (cnt_q == 5'(IP_HDR_DEFLEN - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_CHECK: begin
                csum_clr_s = 1'b1;
                if (ip_hdr_ok(iphdr'(shift_q), csum_s, CHECK_DADDR, LOCAL_ADDR)) begin
                    hdr_d       = iphdr'(shift_q);
                    hdr_valid_d = 1'b1;
                    rem_d       = shift_q[143:128] - 16'(IP_HDR_DEFLEN);
                    state_d     = ST_PAYLOAD;
                end else begin
                    bad_s   = 1'b1;
                    state_d = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (s_fire_s) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_tdata;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        m_tlast_d = 1'b1;
                        state_d   = s_tlast ? ST_HDR : ST_DROP;
                    end else if (s_tlast) begin
                        m_tlast_d = 1'b1;
                        len_err_d = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        m_tlast_d = 1'b0;
                        state_d   = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                if (s_fire_s && s_tlast) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // Main state and output registers
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state_q     <= ST_HDR;
            shift_q     <= 160'd0;
            cnt_q       <= 5'd0;
            rem_q       <= 16'd0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            len_err_q   <= len_err_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign hdr       = hdr_q;
    assign hdr_valid = hdr_valid_q;
    assign len_err   = len_err_q;

`ifdef IP_RX_FILTER_STATS_EN
    logic [31:0] stat_ok_q, stat_ok_d;
    logic [31:0] stat_bad_q, stat_bad_d;
    logic [31:0] stat_runt_q, stat_runt_d;

    // Free-running event counters, wrapping naturally at 2^32.
    always_comb begin
        stat_ok_d   = stat_ok_q;
        stat_bad_d  = stat_bad_q;
        stat_runt_d = stat_runt_q;
        if (hdr_valid_d) begin
            stat_ok_d = stat_ok_q + 32'd1;
        end else begin
            stat_ok_d = stat_ok_q;
        end
        if (bad_s) begin
            stat_bad_d = stat_bad_q + 32'd1;
        end else begin
            stat_bad_d = stat_bad_q;
        end
        if (runt_s) begin
            stat_runt_d = stat_runt_q + 32'd1;
        end else begin
            stat_runt_d = stat_runt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            stat_ok_q   <= 32'd0;
            stat_bad_q  <= 32'd0;
            stat_runt_q <= 32'd0;
        end else begin
            stat_ok_q   <= stat_ok_d;
            stat_bad_q  <= stat_bad_d;
            stat_runt_q <= stat_runt_d;
        end
    end

    assign stat_ok   = stat_ok_q;
    assign stat_bad  = stat_bad_q;
    assign stat_runt = stat_runt_q;
`else
    logic stats_unused_s;
    assign stats_unused_s = bad_s ^ runt_s;
`endif

endmodule

// File: tb/tb_ip_rx_filter.sv
// Self-checking bench for ip_rx_filter: frame-level reference model plus per-cycle output compare.
module tb_ip_rx_filter;
    import ip_pkg::*;

    localparam logic [31:0] LOCAL = 32'hC0A8_0165;
    localparam logic [31:0] OTHER = 32'hC0A8_0266;

    logic       clk;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       s_tvalid0, s_tvalid1;
    logic       m_tready;
    logic       toggle_mode;

    logic       s_tready0, s_tready1;
    logic [7:0] m_tdata0, m_tdata1;
    logic       m_tvalid0, m_tvalid1;
    logic       m_tlast0, m_tlast1;
    iphdr       hdr0, hdr1;
    logic       hdr_valid0, hdr_valid1;
    logic       len_err0, len_err1;
`ifdef IP_RX_FILTER_STATS_EN
    logic [31:0] st_ok0, st_bad0, st_runt0, st_ok1, st_bad1, st_runt1;
`endif

    ip_rx_filter #(.LOCAL_ADDR(LOCAL), .CHECK_DADDR(1'b1)) u0 (
        .clk156(clk), .eth_rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid0), .s_tready(s_tready0),
        .s_tlast(s_tlast), .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .m_tlast(m_tlast0), .hdr(hdr0), .hdr_valid(hdr_valid0), .len_err(len_err0)
`ifdef IP_RX_FILTER_STATS_EN
        , .stat_ok(st_ok0), .stat_bad(st_bad0), .stat_runt(st_runt0)
`endif
    );

    ip_rx_filter #(.LOCAL_ADDR(LOCAL), .CHECK_DADDR(1'b0)) u1 (
        .clk156(clk), .eth_rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid1), .s_tready(s_tready1),
        .s_tlast(s_tlast), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .m_tlast(m_tlast1), .hdr(hdr1), .hdr_valid(hdr_valid1), .len_err(len_err1)
`ifdef IP_RX_FILTER_STATS_EN
        , .stat_ok(st_ok1), .stat_bad(st_bad1), .stat_runt(st_runt1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   frm[$];
    logic [8:0]   exp_d0[$], exp_d1[$];
    logic [159:0] exp_h0[$], exp_h1[$];
    int exp_le[2], exp_ok[2], exp_bad[2], exp_runt[2];
    int obs_le0 = 0, obs_le1 = 0;
    int beats0 = 0, beats1 = 0, run0 = 0, run1 = 0, last_at0 = 0, last_at1 = 0;
    int hv0 = 0, hv1 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = toggle_mode ? ~m_tready : 1'b1;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_hdr(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Build a frame: 20-byte header (correct checksum XOR cx) then patterned bytes up to nbytes.
    task automatic build(input int nbytes, input logic [15:0] tl, input logic [31:0] da,
                         input logic [7:0] proto, input logic [15:0] cx);
        int unsigned s;
        logic [15:0] ck;
        frm.delete();
        frm = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, proto,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h02, da[31:24], da[23:16], da[15:8], da[7:0]};
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'h0000, frm[2*w], frm[2*w+1]};
        while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
        ck = ~s[15:0] ^ cx;
        frm[10] = ck[15:8];
        frm[11] = ck[7:0];
        for (int i = 20; i < nbytes; i++) frm.push_back(8'((i * 13 + 5) & 255));
    endtask

    // Reference: the frame in frm, delivered from an idle receiver, yields these outputs.
    task automatic model(input int dut);
        int n, rem, avail, k;
        int unsigned s;
        logic [159:0] h;
        logic [15:0] tl;
        logic [31:0] da;
        bit ok;
        n = frm.size();
        if (n < 20) begin
            exp_runt[dut]++;
        end else if (n == 20) begin
            exp_bad[dut]++;
        end else begin
            h = '0;
            for (int i = 0; i < 20; i++) h = {h[151:0], frm[i]};
            s = 0;
            for (int w = 0; w < 10; w++) s += {16'h0000, frm[2*w], frm[2*w+1]};
            while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
            tl = {frm[2], frm[3]};
            da = {frm[16], frm[17], frm[18], frm[19]};
            ok = (s == 32'h0000_FFFF) && (frm[0] == 8'h45) && (frm[9] == 8'h11) &&
                 (tl >= 16'd28) && (dut == 1 || da == LOCAL);
            if (ok) begin
                exp_ok[dut]++;
                rem   = int'(tl) - 20;
                avail = n - 20;
                k     = (avail < rem) ? avail : rem;
                if (dut == 0) exp_h0.push_back(h); else exp_h1.push_back(h);
                for (int j = 0; j < k; j++) begin
                    if (dut == 0) exp_d0.push_back({j == k - 1, frm[20 + j]});
                    else          exp_d1.push_back({j == k - 1, frm[20 + j]});
                end
                if (avail < rem) exp_le[dut]++;
            end else begin
                exp_bad[dut]++;
            end
        end
    endtask

    task automatic send(input int dut, input int n, input bit with_last);
        bit done;
        for (int i = 0; i < n; i++) begin
            s_tdata = frm[i];
            s_tlast = with_last && (i == n - 1);
            if (dut == 0) s_tvalid0 = 1'b1; else s_tvalid1 = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if ((dut == 0) ? s_tready0 : s_tready1) done = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: byte %0d never accepted by dut %0d", i, dut);
                i = n;
            end
        end
        s_tvalid0 = 1'b0;
        s_tvalid1 = 1'b0;
        s_tlast   = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_d0.size() + exp_d1.size() + exp_h0.size() + exp_h1.size()) != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk32("pending_expected", 32'(exp_d0.size() + exp_d1.size() + exp_h0.size() + exp_h1.size()), 32'd0);
        chk32("u0_len_err_count", 32'(obs_le0), 32'(exp_le[0]));
        chk32("u1_len_err_count", 32'(obs_le1), 32'(exp_le[1]));
`ifdef IP_RX_FILTER_STATS_EN
        chk32("u0_stat_ok", st_ok0, 32'(exp_ok[0]));
        chk32("u0_stat_bad", st_bad0, 32'(exp_bad[0]));
        chk32("u0_stat_runt", st_runt0, 32'(exp_runt[0]));
        chk32("u1_stat_ok", st_ok1, 32'(exp_ok[1]));
`endif
    endtask

    // Per-cycle compare of both DUTs against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid0 && m_tready) begin
                if (exp_d0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u0_extra_beat: got %0h expected no output", {m_tlast0, m_tdata0});
                end else begin
                    chk32("u0_beat", 32'({m_tlast0, m_tdata0}), 32'(exp_d0.pop_front()));
                end
                beats0++; run0++;
                if (m_tlast0) begin last_at0 = run0; run0 = 0; end
            end
            if (m_tvalid1 && m_tready) begin
                if (exp_d1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u1_extra_beat: got %0h expected no output", {m_tlast1, m_tdata1});
                end else begin
                    chk32("u1_beat", 32'({m_tlast1, m_tdata1}), 32'(exp_d1.pop_front()));
                end
                beats1++; run1++;
                if (m_tlast1) begin last_at1 = run1; run1 = 0; end
            end
            if (hdr_valid0) begin
                hv0++;
                if (exp_h0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u0_extra_hdr_valid: got %h expected none", hdr0);
                end else chk_hdr("u0_hdr", hdr0, exp_h0.pop_front());
            end
            if (hdr_valid1) begin
                hv1++;
                if (exp_h1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u1_extra_hdr_valid: got %h expected none", hdr1);
                end else chk_hdr("u1_hdr", hdr1, exp_h1.pop_front());
            end
            if (len_err0) obs_le0++;
            if (len_err1) obs_le1++;
            if (m_tvalid0 && !m_tready && !m_tlast0) chk32("u0_backpressure_s_tready", 32'(s_tready0), 32'd0);
        end
    end

    initial begin
        int b, h;
        rst = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0; s_tvalid0 = 1'b0; s_tvalid1 = 1'b0;
        toggle_mode = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_le[d] = 0; exp_ok[d] = 0; exp_bad[d] = 0; exp_runt[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk32("rst_s_tready", 32'(s_tready0), 32'd0);
        chk32("rst_outs", 32'({m_tvalid0, m_tlast0, m_tdata0, hdr_valid0, len_err0}), 32'd0);
        chk_hdr("rst_hdr", hdr0, 160'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk32("idle_s_tready", 32'(s_tready0), 32'd1);
        @(posedge clk); #1;

        // 1: good 60-byte frame, tot_len 46
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        chk32("t1_model_beats", 32'(exp_d0.size()), 32'd26);
        b = beats0; h = hv0;
        send(0, 60, 1'b1);
        drain();
        chk32("t1_beats", 32'(beats0 - b), 32'd26);
        chk32("t1_last_at", 32'(last_at0), 32'd26);
        chk32("t1_hdr_valid_count", 32'(hv0 - h), 32'd1);
        chk32("t1_tot_len", 32'(hdr0.tot_len), 32'd46);
        chk32("t1_daddr", hdr0.daddr, LOCAL);

        // 2: corrupted check field, then a good frame
        build(60, 16'd46, LOCAL, 8'h11, 16'h0001);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("t2_bad_beats", 32'(beats0 - b), 32'd0);
`ifdef IP_RX_FILTER_STATS_EN
        chk32("t2_stat_bad_lit", st_bad0, 32'd1);
`endif
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("t2_good_beats", 32'(beats0 - b), 32'd26);

        // 3: runt of 12 bytes, then a good frame
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        frm = frm[0:11];
        model(0);
        b = beats0;
        send(0, 12, 1'b1);
        drain();
        chk32("t3_runt_beats", 32'(beats0 - b), 32'd0);
`ifdef IP_RX_FILTER_STATS_EN
        chk32("t3_stat_runt_lit", st_runt0, 32'd1);
`endif
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("t3_good_beats", 32'(beats0 - b), 32'd26);

        // 4: tot_len 100 but only 40 payload bytes present
        build(60, 16'd100, LOCAL, 8'h11, 16'h0000);
        model(0);
        chk32("t4_model_beats", 32'(exp_d0.size()), 32'd40);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("t4_beats", 32'(beats0 - b), 32'd40);
        chk32("t4_last_at", 32'(last_at0), 32'd40);
        chk32("t4_len_err_lit", 32'(obs_le0), 32'd1);

        // 5: output backpressure toggling every cycle
        toggle_mode = 1'b1;
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        toggle_mode = 1'b0;
        chk32("t5_beats", 32'(beats0 - b), 32'd26);
        chk32("t5_last_at", 32'(last_at0), 32'd26);

        // 6: foreign daddr, dropped with the address check, forwarded without it
        build(60, 16'd46, OTHER, 8'h11, 16'h0000);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("t6_u0_beats", 32'(beats0 - b), 32'd0);
        chk32("t6_u0_hdr_held_daddr", hdr0.daddr, LOCAL);
        chk32("t6_u0_hdr_held_len", 32'(hdr0.tot_len), 32'd46);
        model(1);
        b = beats1;
        send(1, 60, 1'b1);
        drain();
        chk32("t6_u1_beats", 32'(beats1 - b), 32'd26);
        chk32("t6_u1_daddr", hdr1.daddr, OTHER);

        // Reset in the middle of the payload
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        send(0, 30, 1'b0);
        @(negedge clk);
        chk32("mid_m_tvalid_before_rst", 32'(m_tvalid0), 32'd1);
        rst = 1'b1;
        #1;
        chk32("mid_rst_outs", 32'({m_tvalid0, m_tlast0, m_tdata0, hdr_valid0, len_err0, s_tready0}), 32'd0);
        chk_hdr("mid_rst_hdr", hdr0, 160'd0);
        exp_d0.delete(); exp_h0.delete(); exp_d1.delete(); exp_h1.delete();
        for (int d = 0; d < 2; d++) begin
            exp_ok[d] = 0; exp_bad[d] = 0; exp_runt[d] = 0;
        end
        run0 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        frm = frm[30:$];
        model(0);
        b = beats0;
        send(0, frm.size(), 1'b1);
        drain();
        chk32("post_rst_remainder_beats", 32'(beats0 - b), 32'd0);
        build(60, 16'd46, LOCAL, 8'h11, 16'h0000);
        model(0);
        b = beats0;
        send(0, 60, 1'b1);
        drain();
        chk32("post_rst_good_beats", 32'(beats0 - b), 32'd26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
